// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the shift-add multiplier accumulation stage.
//   MULT_W    : default operand width of the multiplier datapath
//   operand_t : one unsigned operand
//   sum_t     : operand sum including the carry-out bit
package mult_pkg;

  localparam int MULT_W = 16;

  typedef logic [MULT_W-1:0] operand_t;
  typedef logic [MULT_W:0]   sum_t;

endpackage : mult_pkg

// File: rtl/mult_adder_if.sv
// mult_adder_if: operand/result bundle of the accumulation adder.
//   operando_a, operando_b : unsigned addends (WIDTH bits)
//   in_valid               : addends are valid this cycle
//   soma                   : registered sum, bit WIDTH is the carry-out
//   out_valid              : soma holds a new result this cycle
// Modports: master drives the operands and reads the result, slave is the adder.
interface mult_adder_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
);

  logic [WIDTH-1:0] operando_a;
  logic [WIDTH-1:0] operando_b;
  logic             in_valid;
  logic [WIDTH:0]   soma;
  logic             out_valid;

  modport master (
    output operando_a,
    output operando_b,
    output in_valid,
    input  soma,
    input  out_valid
  );

  modport slave (
    input  operando_a,
    input  operando_b,
    input  in_valid,
    output soma,
    output out_valid
  );

endinterface : mult_adder_if

// File: rtl/cla_block.sv
// cla_block: BLK-bit combinational carry-lookahead adder slice.
//   a, b : BLK-bit addend slices
//   cin  : carry into the slice
//   sum  : BLK-bit sum slice
//   cout : carry out of the slice
// Every internal carry is formed as a flat sum of products
// (g[i] | p[i]g[i-1] | ... | p[i..0]cin) rather than rippled bit by bit.
module cla_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout
);

  logic [BLK-1:0] gen_s;
  logic [BLK-1:0] prop_s;
  logic [BLK:0]   carry_s;
  logic           term_s;
  logic           acc_s;

  assign gen_s  = a & b;
  assign prop_s = a ^ b;

  // Two-level lookahead: each carry is the OR of all generate terms
  // propagated up to it, plus cin propagated through every lower bit.
  always_comb begin
    carry_s    = '0;
    term_s     = 1'b0;
    acc_s      = 1'b0;
    carry_s[0] = cin;
    for (int i = 0; i < BLK; i++) begin
      term_s = cin;
      for (int k = 0; k <= i; k++) begin
        term_s = term_s & prop_s[k];
      end
      acc_s = term_s;
      for (int j = 0; j <= i; j++) begin
        term_s = gen_s[j];
        for (int k = j + 1; k <= i; k++) begin
          term_s = term_s & prop_s[k];
        end
        acc_s = acc_s | term_s;
      end
      carry_s[i+1] = acc_s;
    end
  end

  assign sum  = prop_s ^ carry_s[BLK-1:0];
  assign cout = carry_s[BLK];

endmodule : cla_block

// File: rtl/mult_adder.sv
// mult_adder: unsigned WIDTH-bit adder with full carry-out, registered
// result and valid flag; partial-product accumulation stage of the
// shift-add multiplier.
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset (clears soma and out_valid)
//   bus   : mult_adder_if slave (operando_a/b, in_valid in; soma, out_valid out)
// One-cycle latency, one result per cycle, no backpressure. soma holds its
// last value while in_valid is low; out_valid marks fresh results only.
module mult_adder
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W,
  parameter int BLK   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mult_adder_if.slave  bus
);

  localparam int NBLK = WIDTH / BLK;

  // Block sizing must tile the operand exactly.
  if ((WIDTH % BLK) != 0) begin : g_width_check
    $error("mult_adder: WIDTH (%0d) must be a multiple of BLK (%0d)", WIDTH, BLK);
  end

  logic [NBLK:0]    chain_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH:0]   soma_r;
  logic             out_valid_r;

  // Carry-in of the accumulation stage is always zero.
  assign chain_s[0] = 1'b0;

  // Lookahead blocks, carries ripple from block to block.
  for (genvar n = 0; n < NBLK; n++) begin : g_blk
    cla_block #(
      .BLK (BLK)
    ) u_cla (
      .a    (bus.operando_a[n*BLK +: BLK]),
      .b    (bus.operando_b[n*BLK +: BLK]),
      .cin  (chain_s[n]),
      .sum  (sum_s[n*BLK +: BLK]),
      .cout (chain_s[n+1])
    );
  end

  // Output and valid registers; reset wins over a coincident valid operand.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      soma_r      <= '0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        soma_r <= {chain_s[NBLK], sum_s};
      end else begin
        soma_r <= soma_r;
      end
    end
  end

  assign bus.soma      = soma_r;
  assign bus.out_valid = out_valid_r;

endmodule : mult_adder

// File: tb/tb_mult_adder.sv
// tb_mult_adder: self-checking bench for mult_adder at default width.
// Directed table of vectors streamed back-to-back, hold/idle and
// reset-override sequences, then randomized traffic against an
// arithmetic reference model.
module tb_mult_adder;
  import mult_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mult_adder_if #(.WIDTH(MULT_W)) bus ();

  mult_adder #(
    .WIDTH (MULT_W),
    .BLK   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    operand_t a;
    operand_t b;
    sum_t     exp;
  } vec_t;

  vec_t tbl [5];

  // Reference model state: what soma/out_valid must be after the last edge.
  sum_t exp_soma;
  logic exp_valid;

  task automatic chk(input string name, input logic [MULT_W:0] act, input logic [MULT_W:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
    end
  endtask

  // Drive inputs, advance one edge, update the model, then compare.
  task automatic cycle(input logic rst_v, input logic vld, input operand_t a, input operand_t b,
                       input string name);
    rst_n          = rst_v;
    bus.in_valid   = vld;
    bus.operando_a = a;
    bus.operando_b = b;
    @(posedge clk);
    if (!rst_v) begin
      exp_soma  = '0;
      exp_valid = 1'b0;
    end else if (vld) begin
      exp_soma  = sum_t'(a) + sum_t'(b);
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    #1;
    chk({name, "_soma"}, bus.soma, exp_soma);
    chk({name, "_valid"}, {16'h0000, bus.out_valid}, {16'h0000, exp_valid});
  endtask

  initial begin
    operand_t ra;
    operand_t rb;
    logic     rv;
    logic     rr;
    errors    = 0;
    checks    = 0;
    exp_soma  = '0;
    exp_valid = 1'b0;

    tbl[0] = '{16'h0000, 16'h0000, 17'h00000};
    tbl[1] = '{16'h0001, 16'h0001, 17'h00002};
    tbl[2] = '{16'hFFFF, 16'h0001, 17'h10000};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};
    tbl[4] = '{16'h8000, 16'h8000, 17'h10000};

    // Reset for two cycles.
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, "reset0");
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, "reset1");

    // Directed vectors, streamed on consecutive cycles; table constants
    // are checked directly in addition to the model.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, tbl[i].a, tbl[i].b, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_table", i), bus.soma, tbl[i].exp);
    end

    // Drop in_valid: result held, valid low.
    cycle(1'b1, 1'b0, 16'h1234, 16'h4321, "idle0");
    chk("idle0_hold", bus.soma, 17'h10000);
    cycle(1'b1, 1'b0, 16'hAAAA, 16'h5555, "idle1");

    // Reset overrides a valid operand on the same edge, and it never reappears.
    cycle(1'b1, 1'b1, 16'h0F0F, 16'h0101, "pre_rst");
    cycle(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, "rst_mid");
    chk("rst_mid_zero", bus.soma, 17'h00000);
    cycle(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, "post_rst");
    chk("post_rst_zero", bus.soma, 17'h00000);

    // Randomized traffic with boundary operands mixed in and occasional resets.
    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 7))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h0000;
        default: ra = operand_t'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 16'hFFFF;
        1:       rb = 16'h0000;
        default: rb = operand_t'($urandom);
      endcase
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 63) != 0);
      cycle(rr, rv, ra, rb, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mult_adder
